// File: rtl/wb_sdram_responder.sv
// Wishbone classic slave modelling an SDRAM endpoint with open-row timing:
// CAS-only access on a row hit, activate then CAS on a row miss.
module wb_sdram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
  parameter int          ADDR_BITS = 10,
  parameter int          ROW_BITS  = 3,
  parameter int          T_ACT     = 3,
  parameter int          T_CAS     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        busy_o,
  output logic        row_open_o
);

  localparam int DEPTH   = 1 << ADDR_BITS;
  localparam int RW      = ADDR_BITS - ROW_BITS;
  localparam int CNT_MAX = (T_ACT > T_CAS) ? T_ACT : T_CAS;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] ACT_LOAD = CW'(T_ACT - 1);
  localparam logic [CW-1:0] CAS_LOAD = CW'(T_CAS - 1);

  typedef enum logic [2:0] {IDLE, ACT, CAS, ACK, ERR} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [RW-1:0]          open_row;
  logic                   row_vld;
  logic                   lat_we;
  logic [3:0]             lat_sel;
  logic [31:0]            lat_dat;
  logic [ADDR_BITS-1:0]   lat_idx;
  logic [31:0]            mem [DEPTH];

  logic                   req;
  logic                   in_range;
  logic [ADDR_BITS-1:0]   req_idx;
  logic [RW-1:0]          req_row;
  logic [RW-1:0]          lat_row;
  logic                   hit;
  logic                   commit;
  logic                   unused_adr;

  assign req        = wbs_cyc_i && wbs_stb_i;
  assign in_range   = (wbs_adr_i[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign req_idx    = wbs_adr_i[ADDR_BITS+1:2];
  assign req_row    = req_idx[ADDR_BITS-1:ROW_BITS];
  assign lat_row    = lat_idx[ADDR_BITS-1:ROW_BITS];
  assign hit        = row_vld && (open_row == req_row);
  // The write lands on the same edge that raises ack, and only if the master is still there.
  assign commit     = (state == CAS) && (cnt == '0) && req && lat_we;
  assign row_open_o = row_vld;
  assign unused_adr = ^wbs_adr_i[1:0];

  // Request capture: data path, no reset
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      lat_we  <= wbs_we_i;
      lat_sel <= wbs_sel_i;
      lat_dat <= wbs_dat_i;
      lat_idx <= req_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_sel[b]) mem[lat_idx][8*b +: 8] <= lat_dat[8*b +: 8];
      end
    end
  end

  // Control FSM: abort on cyc/stb drop in ACT or CAS
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      busy_o    <= 1'b0;
      open_row  <= '0;
      row_vld   <= 1'b0;
    end else begin
      wbs_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req && !wbs_ack_o) begin
            busy_o <= 1'b1;
            if (!in_range) begin
              state     <= ERR;
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= '0;
            end else if (hit) begin
              state <= CAS;
              cnt   <= CAS_LOAD;
            end else begin
              state <= ACT;
              cnt   <= ACT_LOAD;
            end
          end
        end
        ACT: begin
          if (!req) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (cnt == '0) begin
            state    <= CAS;
            cnt      <= CAS_LOAD;
            open_row <= lat_row;
            row_vld  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CAS: begin
          if (!req) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (cnt == '0) begin
            state     <= ACK;
            wbs_ack_o <= 1'b1;
            if (!lat_we) wbs_dat_o <= mem[lat_idx];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sdram_responder.sv
// Directed bench for wb_sdram_responder: a reference memory/open-row model
// feeds a scoreboard queue that is checked against each acknowledge.
module tb_wb_sdram_responder;

  localparam int          T_ACT = 3;
  localparam int          T_CAS = 2;
  localparam logic [31:0] BASE  = 32'h3800_0000;
  localparam int          LAT_HIT  = T_CAS + 1;
  localparam int          LAT_MISS = T_ACT + T_CAS + 1;

  logic        clk;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        busy_o, row_open_o;

  wb_sdram_responder #(
    .BASE_ADDR(BASE), .ADDR_BITS(10), .ROW_BITS(3), .T_ACT(T_ACT), .T_CAS(T_CAS)
  ) dut (
    .clk(clk), .rst(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .busy_o(busy_o), .row_open_o(row_open_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] dat;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [int];
  int          mrow;
  bit          mvld;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // extra = 1 when the previous transfer left stb high (one ACK->IDLE edge precedes sampling)
  task automatic xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input bit keep, input int extra, input string tag);
    exp_t        e;
    exp_t        got_e;
    int          idx, row, n;
    bit          got;
    logic [31:0] old;
    e.rd  = !w;
    e.dat = '0;
    if (a[31:12] != BASE[31:12]) begin
      e.lat = 1;
    end else begin
      idx = int'(a[11:2]);
      row = idx >> 3;
      if (mvld && mrow == row) e.lat = LAT_HIT;
      else begin
        e.lat = LAT_MISS;
        mrow  = row;
        mvld  = 1'b1;
      end
      old = mdl.exists(idx) ? mdl[idx] : 32'h0;
      if (w) begin
        for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = d[8*b +: 8];
        mdl[idx] = old;
      end else begin
        e.dat = old;
      end
    end
    sbq.push_back(e);
    we = w; adr = a; sel = s; wdat = d; cyc = 1'b1; stb = 1'b1;
    n = 0; got = 1'b0;
    while (n < 30 && !got) begin
      tick();
      n++;
      if (wbs_ack_o) got = 1'b1;
    end
    got_e = sbq.pop_front();
    check({tag, "_ack"}, 32'(got), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(got_e.lat + extra));
    if (got_e.rd) check({tag, "_dat"}, wbs_dat_o, got_e.dat);
    if (!keep) begin
      cyc = 1'b0; stb = 1'b0;
      tick();
      check({tag, "_ack1cyc"}, 32'(wbs_ack_o), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    mvld = 1'b0; mrow = 0;
    tick(); tick();
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_row", 32'(row_open_o), 32'd0);
    rst = 1'b1;
    tick();

    // write miss then read hit on word 0
    xfer(1'b1, BASE, 4'hF, 32'hDEAD_BEEF, 1'b0, 0, "t1_wr");
    xfer(1'b0, BASE, 4'hF, 32'h0, 1'b0, 0, "t1_rd");
    check("t1_row_open", 32'(row_open_o), 32'd1);

    // byte lanes on word 32 (row 4)
    xfer(1'b1, BASE + 32'h80, 4'hF, 32'h0, 1'b0, 0, "t2_clr");
    xfer(1'b1, BASE + 32'h80, 4'b0101, 32'h1122_3344, 1'b0, 0, "t2_wr");
    xfer(1'b0, BASE + 32'h80, 4'h0, 32'h0, 1'b0, 0, "t2_rd");
    check("t2_lanes", wbs_dat_o, 32'h0022_0044);
    xfer(1'b1, BASE + 32'h80, 4'h0, 32'hFFFF_FFFF, 1'b0, 0, "t2_sel0");
    xfer(1'b0, BASE + 32'h80, 4'hF, 32'h0, 1'b0, 0, "t2_sel0_rd");

    // preload words for later steps, ending with row 1 open
    xfer(1'b1, BASE + 32'h0A0, 4'hF, 32'hA5A5_0040, 1'b0, 0, "pre40");
    xfer(1'b1, BASE + 32'h190, 4'hF, 32'hC0FF_EE64, 1'b0, 0, "pre100");
    for (int i = 0; i < 12; i++)
      xfer(1'b1, BASE + 32'(4 * i), 4'hF, 32'h1000_0000 + 32'(i), 1'b0, 0, "pre_stream");

    // back-to-back read stream with stb held high
    for (int i = 0; i < 12; i++)
      xfer(1'b0, BASE + 32'(4 * i), 4'hF, 32'h0, (i != 11), (i == 0) ? 0 : 1, "t3_stream");

    // out of range
    xfer(1'b0, 32'h3800_1000, 4'hF, 32'h0, 1'b0, 0, "t4_oor");
    check("t4_row_kept", 32'(row_open_o), 32'd1);

    // abort a write to row 5 during CAS
    we = 1'b1; adr = BASE + 32'h0A0; sel = 4'hF; wdat = 32'h0BAD_0BAD; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < T_ACT + 1; i++) tick();
    check("t5_busy_cas", 32'(busy_o), 32'd1);
    check("t5_no_ack_cas", 32'(wbs_ack_o), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    tick();
    check("t5_busy_abort", 32'(busy_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("t5_no_ack", 32'(wbs_ack_o), 32'd0);
      tick();
    end
    mrow = 5; mvld = 1'b1;
    check("t5_row_open", 32'(row_open_o), 32'd1);
    xfer(1'b0, BASE + 32'h0A0, 4'hF, 32'h0, 1'b0, 0, "t5_hit");

    // reset during ACT of a write to word 100
    we = 1'b1; adr = BASE + 32'h190; sel = 4'hF; wdat = 32'h0BAD_CAFE; cyc = 1'b1; stb = 1'b1;
    tick(); tick();
    check("t6_busy_act", 32'(busy_o), 32'd1);
    rst = 1'b0;
    #1;
    check("t6_ack", 32'(wbs_ack_o), 32'd0);
    check("t6_busy", 32'(busy_o), 32'd0);
    check("t6_row", 32'(row_open_o), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    tick();
    rst = 1'b1;
    mvld = 1'b0;
    tick();
    xfer(1'b0, BASE + 32'h190, 4'hF, 32'h0, 1'b0, 0, "t6_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
